// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, sample/coefficient/accumulator types and FSM states
// for the time-multiplexed symmetric FIR.
package fir_pkg;
   localparam int DATA_W   = 24;
   localparam int COEFF_W  = 16;
   localparam int TAP_FULL = 101;
   localparam int TAP_HALF = (TAP_FULL + 1) / 2;
   localparam int ACC_W    = 48;
   localparam int PTR_W    = $clog2(TAP_FULL);
   localparam int K_W      = $clog2(TAP_HALF);
   localparam int PAIR_W   = DATA_W + 1;
   localparam int PROD_W   = PAIR_W + COEFF_W;
   typedef logic signed [DATA_W-1:0]  sample_t;
   typedef logic signed [COEFF_W-1:0] coeff_t;
   typedef logic signed [ACC_W-1:0]   acc_t;
   typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} fir_state_e;
endpackage

// File: rtl/fir_hist_buf.sv
// fir_hist_buf: circular sample history with one write port and two
// combinational taps x[n-j] and x[n-(TAP_FULL-1-j)].
module fir_hist_buf
   import fir_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_we,
   input  logic signed [DATA_W-1:0] i_wdata,
   input  logic [PTR_W-1:0]        i_j,
   output logic signed [DATA_W-1:0] o_rd_a,
   output logic signed [DATA_W-1:0] o_rd_b
);
   sample_t          r_mem [TAP_FULL];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] w_newest, w_jb, w_idx_a, w_idx_b;
   // modular subtraction stays in PTR_W bits: the true result is always < TAP_FULL
   always_comb begin
      w_newest = (r_wr_ptr == '0) ? PTR_W'(TAP_FULL - 1) : r_wr_ptr - PTR_W'(1);
      w_jb     = PTR_W'(TAP_FULL - 1) - i_j;
      w_idx_a  = (w_newest >= i_j) ? w_newest - i_j : w_newest + PTR_W'(TAP_FULL) - i_j;
      w_idx_b  = (w_newest >= w_jb) ? w_newest - w_jb : w_newest + PTR_W'(TAP_FULL) - w_jb;
   end
   assign o_rd_a = r_mem[w_idx_a];
   assign o_rd_b = r_mem[w_idx_b];
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         for (int i = 0; i < TAP_FULL; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[r_wr_ptr] <= i_wdata;
         r_wr_ptr        <= (r_wr_ptr == PTR_W'(TAP_FULL - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
   end
endmodule

// File: rtl/fir_mac_sched.sv
// fir_mac_sched: one pre-adder, one multiplier, one accumulator symmetric FIR.
// Define FIR_MAC_SAT_EN to saturate the output instead of wrapping.
module fir_mac_sched
   import fir_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic signed [DATA_W-1:0]  s_data,
   output logic [K_W-1:0]            coef_addr,
   input  logic signed [COEFF_W-1:0] coef_data,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic signed [DATA_W-1:0]  m_data,
   output logic                      busy
);
   fir_state_e              r_state;
   logic [K_W-1:0]          r_k;
   logic signed [PAIR_W-1:0] r_pair;
   logic signed [PROD_W-1:0] r_prod;
   acc_t                    r_acc;
   logic                    r_v1, r_v2, r_m_valid;
   logic [DATA_W-1:0]       r_m_data;
   sample_t                 w_rd_a, w_rd_b;
   logic signed [PAIR_W-1:0] w_pair;
   logic [DATA_W-1:0]       w_out;
   logic                    w_center;
   fir_hist_buf u_hist (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (s_valid & s_ready),
      .i_wdata (s_data),
      .i_j     (PTR_W'(r_k)),
      .o_rd_a  (w_rd_a),
      .o_rd_b  (w_rd_b)
   );
   // the centre tap reads the same slot on both ports and must not be doubled
   always_comb begin
      w_center = r_k == K_W'(TAP_HALF - 1);
      w_pair   = PAIR_W'(w_rd_a) + (w_center ? '0 : PAIR_W'(w_rd_b));
`ifdef FIR_MAC_SAT_EN
      w_out = (&r_acc[ACC_W-1:DATA_W+COEFF_W-2] | ~|r_acc[ACC_W-1:DATA_W+COEFF_W-2])
            ? r_acc[DATA_W+COEFF_W-2:COEFF_W-1]
            : {r_acc[ACC_W-1], {(DATA_W-1){~r_acc[ACC_W-1]}}};
`else
      w_out = r_acc[DATA_W+COEFF_W-2:COEFF_W-1];
`endif
   end
   assign s_ready   = rst_n & (r_state == IDLE);
   assign busy      = r_state != IDLE;
   assign coef_addr = r_k;
   assign m_valid   = r_m_valid;
   assign m_data    = r_m_data;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_k       <= '0;
         r_pair    <= '0;
         r_prod    <= '0;
         r_acc     <= '0;
         r_v1      <= 1'b0;
         r_v2      <= 1'b0;
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
      end else begin
         r_pair <= w_pair;
         r_prod <= PROD_W'(r_pair) * PROD_W'(coef_data);
         r_v1   <= r_state == MAC;
         r_v2   <= r_v1;
         if (r_v2) r_acc <= r_acc + acc_t'(r_prod);
         case (r_state)
            IDLE: if (s_valid) begin
               r_acc   <= '0;
               r_k     <= '0;
               r_state <= MAC;
            end
            MAC: begin
               r_k     <= w_center ? '0 : r_k + K_W'(1);
               r_state <= w_center ? DRAIN : MAC;
            end
            DRAIN: begin
               r_k     <= (r_k == K_W'(1)) ? '0 : r_k + K_W'(1);
               r_state <= (r_k == K_W'(1)) ? OUT : DRAIN;
            end
            OUT: if (r_m_valid && m_ready) begin
               r_m_valid <= 1'b0;
               r_state   <= IDLE;
            end else if (!r_m_valid) begin
               r_m_valid <= 1'b1;
               r_m_data  <= w_out;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fir_mac_sched.sv
// tb_fir_mac_sched: directed and randomized checks of fir_mac_sched against a
// direct-convolution model; honours FIR_MAC_SAT_EN like the design.
module tb_fir_mac_sched;
   import fir_pkg::*;
   logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, m_ready = 1'b1;
   logic s_ready, m_valid, busy;
   logic [DATA_W-1:0]  s_data = '0, m_data;
   logic [K_W-1:0]     coef_addr;
   logic [COEFF_W-1:0] coef_data = '0;
   int rom [TAP_HALF];
   int hist [$];
   int n_chk = 0, n_pass = 0, cyc = 0;
   logic [23:0] imp_resp [102];
   logic [23:0] got;

   fir_mac_sched dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .coef_addr(coef_addr), .coef_data(coef_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) coef_data <= 16'(rom[coef_addr]);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int rnd(input int w);
      logic [31:0] r;
      r = $urandom;
      return (w == 24) ? int'($signed(r[23:0])) : int'($signed(r[15:0]));
   endfunction

   // y[n] = sum_j h[j] * x[n-j], h symmetric about the centre tap
   function automatic logic [23:0] expect_out();
      longint acc = 0;
      longint sh;
      for (int j = 0; j < TAP_FULL; j++)
         acc += longint'(j < hist.size() ? hist[j] : 0) * longint'(rom[j < TAP_HALF ? j : TAP_FULL - 1 - j]);
      sh = acc >>> 15;
`ifdef FIR_MAC_SAT_EN
      if (sh > 64'sd8388607) sh = 64'sd8388607;
      else if (sh < -64'sd8388608) sh = -64'sd8388608;
`endif
      return sh[23:0];
   endfunction

   task automatic run_sample(input int x, input int hold, input bit keep, input int nxt, output logic [23:0] res);
      int t, c0;
      bit ok;
      logic [23:0] exp, held;
      s_valid = 1'b1;
      s_data  = x[23:0];
      t = 0;
      while (s_ready !== 1'b1 && t < 300) begin @(negedge clk); t++; end
      check("accept_wait", t < 300, 1);
      c0 = cyc + 1;
      hist.push_front(x);
      if (hist.size() > TAP_FULL) void'(hist.pop_back());
      exp = expect_out();
      @(negedge clk);
      s_valid = keep;
      s_data  = nxt[23:0];
      ok = 1'b1;
      t  = 0;
      while (m_valid !== 1'b1 && t < 100) begin
         if (s_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
         @(negedge clk);
         t++;
      end
      check("latency", cyc - c0, 54);
      check("m_data", m_data, exp);
      res  = m_data;
      held = m_data;
      if (hold > 0) begin
         m_ready = 1'b0;
         repeat (hold) begin
            @(negedge clk);
            if (m_valid !== 1'b1 || m_data !== held || s_ready !== 1'b0) ok = 1'b0;
         end
         m_ready = 1'b1;
      end
      check("busy_hold", ok, 1);
      @(negedge clk);
      check("release", {m_valid, s_ready, busy}, 3'b010);
   endtask

   initial begin
      int t, xa, xb;
      bit ok;
      repeat (3) @(negedge clk);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_coef_addr", coef_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_s_ready", s_ready, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_s_ready", s_ready, 1);

      for (int i = 0; i < TAP_HALF; i++) rom[i] = 32'h4000;
      for (int i = 0; i < 102; i++) begin
         run_sample(i == 0 ? 32'sh200000 : 0, 0, 1'b0, 0, got);
         imp_resp[i] = got;
         check("impulse", got, i < 101 ? 24'h100000 : 24'h0);
      end
      for (int i = 0; i < 101; i++) begin
         run_sample(i == 0 ? -32'sh200000 : 0, 0, 1'b0, 0, got);
         check("neg_impulse", got, 24'hF00000);
      end

      xa = rnd(24);
      xb = rnd(24);
      run_sample(xa, 10, 1'b1, xb, got);
      run_sample(xb, 0, 1'b0, 0, got);

      for (int i = 0; i < TAP_HALF; i++) rom[i] = rnd(16);
      for (int i = 0; i < 40; i++) run_sample(rnd(24), int'($urandom_range(0, 3)), 1'b0, 0, got);

      for (int i = 0; i < TAP_HALF; i++) rom[i] = 32'h7FFF;
      for (int i = 0; i < 101; i++) run_sample(32'sh7FFFFF, 0, 1'b0, 0, got);
`ifdef FIR_MAC_SAT_EN
      check("overflow_sat", got, 24'h7FFFFF);
`else
      check("overflow_wrap", got, expect_out());
`endif

      for (int i = 0; i < TAP_HALF; i++) rom[i] = 32'h4000;
      s_valid = 1'b1;
      s_data  = 24'h123456;
      @(negedge clk);
      s_valid = 1'b0;
      t = 0;
      while (coef_addr !== 6'd20 && t < 60) begin @(negedge clk); t++; end
      check("mid_mac_k", coef_addr, 20);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      hist.delete();
      ok = 1'b1;
      repeat (70) begin
         @(negedge clk);
         if (m_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
      end
      check("mid_reset_quiet", ok, 1);
      for (int i = 0; i < 102; i++) begin
         run_sample(i == 0 ? 32'sh200000 : 0, 0, 1'b0, 0, got);
         check("impulse_repeat", got, imp_resp[i]);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
